// File: rtl/serial_ripple_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The requester drives the operands and start; the subtractor returns status and the registered result.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial A - B: one full-subtractor cell reused over WIDTH clocks, with the borrow kept in a flop.
// The result is registered on the last bit and held until the next operation finishes.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  serial_ripple_subtractor_if.slave bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_borrow_out;
  logic [CW-1:0]    r_cnt;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
  logic [WIDTH-1:0] w_work_next;

  // Full-subtractor cell on the operand LSBs.
  assign w_ai        = r_a[0];
  assign w_bi        = r_b[0];
  assign w_d         = w_ai ^ w_bi ^ r_borrow;
  assign w_bout      = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
  assign w_last      = (r_cnt == LAST);
  assign w_work_next = {w_d, r_work[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: default assignment first so the combinational block never infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:                 w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset so an aborted operation leaves no stale result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_work       <= '0;
      r_diff       <= '0;
      r_borrow     <= 1'b0;
      r_borrow_out <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_work   <= w_work_next;
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_bout;
          if (w_last) begin
            r_diff       <= w_work_next;
            r_borrow_out <= w_bout;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status decodes only registered state, so there is no input-to-output path.
  always_comb begin
    bus.busy       = (r_state == S_RUN);
    bus.done       = (r_state == S_DONE);
    bus.diff       = r_diff;
    bus.borrow_out = r_borrow_out;
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench: directed corners and handshake cases at WIDTH=4, random sweep at WIDTH=8,
// both compared against plain modular arithmetic.
module tb_serial_ripple_subtractor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Last completed result of the WIDTH=4 unit, {borrow_out, diff}.
  logic [4:0] last4 = '0;

  serial_ripple_subtractor_if #(.WIDTH(4)) if4 ();
  serial_ripple_subtractor_if #(.WIDTH(8)) if8 ();

  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  serial_ripple_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start4(input logic [3:0] a, input logic [3:0] b);
    if4.start = 1'b1;
    if4.a     = a;
    if4.b     = b;
    step();
    if4.start = 1'b0;
  endtask

  // Called just after the accepting edge; scrambles operands while running.
  task automatic finish4(input string tag, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] exp_d;
    logic       exp_b;
    int         n  = 0;
    int         nb = 0;
    exp_d = a - b;
    exp_b = (a < b);
    while (!if4.done && n < 12) begin
      if (n == 1) check({tag, ".hold_run"}, {if4.borrow_out, if4.diff}, last4);
      nb += int'(if4.busy);
      if4.a = 4'($urandom);
      if4.b = 4'($urandom);
      step();
      n++;
    end
    check({tag, ".lat"},  n, 4);
    check({tag, ".busy"}, nb, 4);
    check({tag, ".done"}, if4.done, 1);
    check({tag, ".diff"}, if4.diff, exp_d);
    check({tag, ".bout"}, if4.borrow_out, exp_b);
    step();
    check({tag, ".pulse"}, if4.done, 0);
    check({tag, ".hold"}, {if4.borrow_out, if4.diff}, {exp_b, exp_d});
    last4 = {exp_b, exp_d};
  endtask

  logic [3:0] va [7] = '{4'd7, 4'd0, 4'd15, 4'd0,  4'd15, 4'd8, 4'd3};
  logic [3:0] vb [7] = '{4'd3, 4'd0, 4'd15, 4'd15, 4'd0,  4'd1, 4'd7};

  initial begin
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] exp8;
    int         n;
    int         dn;

    if4.start = 1'b0; if4.a = '0; if4.b = '0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0;

    repeat (3) step();
    check("reset4", {if4.busy, if4.done, if4.borrow_out, if4.diff}, 0);
    check("reset8", {if8.busy, if8.done, if8.borrow_out, if8.diff}, 0);
    rst_n = 1'b1;
    step();

    // Directed values and corners.
    for (int i = 0; i < 7; i++) begin
      start4(va[i], vb[i]);
      finish4($sformatf("op%0d_%0d_%0d", i, va[i], vb[i]), va[i], vb[i]);
    end
    repeat (3) step();
    check("idle_hold", {if4.borrow_out, if4.diff}, {1'b1, 4'd12});

    // start held high with operands changing: first capture wins, DONE ignores start.
    if4.start = 1'b1;
    if4.a     = 4'd9;
    if4.b     = 4'd4;
    step();
    n = 0;
    while (!if4.done && n < 12) begin
      if4.a = 4'($urandom);
      if4.b = 4'($urandom);
      step();
      n++;
    end
    check("held.lat",  n, 4);
    check("held.diff", if4.diff, 4'd5);
    check("held.bout", if4.borrow_out, 0);
    if4.a = 4'd2;
    if4.b = 4'd6;
    step();
    check("held.idle", {if4.busy, if4.done}, 0);
    step();
    check("held.restart", if4.busy, 1);
    if4.start = 1'b0;
    last4 = {1'b0, 4'd5};
    finish4("held2", 4'd2, 4'd6);

    // Asynchronous reset in the middle of RUN.
    start4(4'd10, 4'd3);
    step();
    #2 rst_n = 1'b0;
    #1 check("rst.async", {if4.busy, if4.done, if4.borrow_out, if4.diff}, 0);
    step();
    step();
    rst_n = 1'b1;
    dn = 0;
    for (int k = 0; k < 8; k++) begin
      dn += int'(if4.done);
      step();
    end
    check("rst.nodone", dn, 0);
    last4 = '0;
    start4(4'd10, 4'd3);
    finish4("post_rst", 4'd10, 4'd3);

    // WIDTH=8 random sweep.
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      case ($urandom_range(0, 7))
        0: a8 = 8'h00;
        1: b8 = 8'hFF;
        2: b8 = a8;
        default: ;
      endcase
      exp8 = a8 - b8;
      if8.start = 1'b1;
      if8.a     = a8;
      if8.b     = b8;
      step();
      if8.start = 1'b0;
      n = 0;
      while (!if8.done && n < 20) begin
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        step();
        n++;
      end
      check("w8.lat",  n, 8);
      check("w8.diff", if8.diff, exp8);
      check("w8.bout", if8.borrow_out, (a8 < b8));
      step();
      check("w8.pulse", if8.done, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
